ram_read_splitter: RTL and testbench

RAM_READ_SPLITTER -- requirements
Module: ram_read_splitter

---
 rtl/ram_read_splitter.sv | 87 ++++++++
 tb/tb_ram_read_splitter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_splitter.sv
// ram_read_splitter: splits 64-bit ring-buffer reads into four 16-bit FWFT lane FIFOs, issuing reads only with credit.
// Define RAM_READ_SPLITTER_LEVEL_EN to expose per-lane fill counts on lane_level.
module ram_read_splitter #(
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rdata,
  input  logic        r_o_ready,
  output logic        r_o_vaild,
  output logic [63:0] lane_data,
  output logic [3:0]  lane_valid,
  input  logic [3:0]  lane_ready
`ifdef RAM_READ_SPLITTER_LEVEL_EN
  ,
  output logic [4*($clog2(DEPTH)+1)-1:0] lane_level
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [RD_LAT-1:0] pipe;
  logic [15:0]       mem [4][DEPTH];
  logic [AW-1:0]     wp [4];
  logic [AW-1:0]     rp [4];
  logic [CW-1:0]     cnt [4];
  logic [31:0]       inflight;
  logic [3:0]        pop;
  logic              accept;
  logic              capture;
  assign accept  = r_o_vaild & r_o_ready;
  assign capture = pipe[RD_LAT-1];
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 32'(pipe[i]);
  end
  // every outstanding read must already have a reserved slot in every lane
  always_comb begin
    r_o_vaild = 1'b1;
    for (int k = 0; k < 4; k++)
      r_o_vaild = (32'(DEPTH) - 32'(cnt[k]) > inflight) ? r_o_vaild : 1'b0;
  end
  always_comb begin
    lane_valid = '0;
    lane_data  = '0;
    pop        = '0;
    for (int k = 0; k < 4; k++) begin
      lane_valid[k]       = cnt[k] != '0;
      lane_data[16*k+:16] = lane_valid[k] ? mem[k][rp[k]] : 16'h0;
      pop[k]              = lane_valid[k] & lane_ready[k];
    end
  end
`ifdef RAM_READ_SPLITTER_LEVEL_EN
  always_comb begin
    lane_level = '0;
    for (int k = 0; k < 4; k++) lane_level[CW*k+:CW] = cnt[k];
  end
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        wp[k]  <= '0;
        rp[k]  <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        wp[k]  <= capture ? wp[k] + AW'(1) : wp[k];
        rp[k]  <= pop[k] ? rp[k] + AW'(1) : rp[k];
        cnt[k] <= cnt[k] + CW'(capture) - CW'(pop[k]);
      end
    end
  end
  // storage is never reset; lane_valid masks stale contents
  always_ff @(posedge clk) begin
    if (capture)
      for (int k = 0; k < 4; k++) mem[k][wp[k]] <= rdata[16*k+:16];
  end
endmodule

// File: tb/tb_ram_read_splitter.sv
// tb_ram_read_splitter: random and directed stimulus with a RAM model and per-lane scoreboard queues.
module tb_ram_read_splitter;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  typedef struct {
    int          due;
    logic [63:0] w;
  } rd_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] rdata = '0;
  logic        r_o_ready = 1'b0;
  logic        r_o_vaild;
  logic [63:0] lane_data;
  logic [3:0]  lane_valid;
  logic [3:0]  lane_ready = '0;
`ifdef RAM_READ_SPLITTER_LEVEL_EN
  logic [4*CW-1:0] lane_level;
`endif
  int          tests = 0;
  int          fails = 0;
  int          mcyc = 0;
  int          acc_total = 0;
  int          pops [4] = '{0, 0, 0, 0};
  logic [63:0] next_word = 64'h0;
  logic [15:0] exp_q [4][$];
  rd_t         ram_q [$];

  ram_read_splitter #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .rdata(rdata),
    .r_o_ready(r_o_ready),
    .r_o_vaild(r_o_vaild),
    .lane_data(lane_data),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready)
`ifdef RAM_READ_SPLITTER_LEVEL_EN
    ,
    .lane_level(lane_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs; the RAM model returns each accepted read RD_LAT cycles later
  task automatic step(input logic rr, input logic [3:0] lr);
    @(posedge clk);
    #1;
    r_o_ready  = rr;
    lane_ready = lr;
    rdata      = {$urandom, $urandom};
    while (ram_q.size() != 0 && ram_q[0].due < mcyc) void'(ram_q.pop_front());
    if (ram_q.size() != 0 && ram_q[0].due == mcyc) rdata = ram_q.pop_front().w;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // monitor: pops and compares whenever a lane hands over data; records accepted reads
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_valid[k] && lane_ready[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("lane%0d_pop_empty", k), 64'd1, 64'd0);
          else check($sformatf("lane%0d_data", k), 64'(lane_data[16*k+:16]), 64'(exp_q[k].pop_front()));
          pops[k]++;
        end
      end
      if (r_o_vaild && r_o_ready) begin
        ram_q.push_back('{mcyc + RD_LAT, next_word});
        for (int k = 0; k < 4; k++) exp_q[k].push_back(next_word[16*k+:16]);
        acc_total++;
        next_word = {$urandom, $urandom};
        for (int k = 0; k < 4; k++)
          check($sformatf("lane%0d_overflow", k), 64'(exp_q[k].size() > DEPTH), 64'd0);
      end
    end
    mcyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, p0, n;
    next_word = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", 64'(r_o_vaild), 64'd1);
    check("reset_lane_valid", 64'(lane_valid), 64'h0);
    check("reset_lane_data", lane_data, 64'h0);
    // release with a single accept in cycle 0
    @(posedge clk);
    #1;
    reset      = 1'b1;
    r_o_ready  = 1'b1;
    lane_ready = 4'hF;
    next_word  = 64'h0004_0003_0002_0001;
    check("rvalid_cycle0", 64'(r_o_vaild), 64'd1);
    step(1'b0, 4'hF);
    step(1'b0, 4'hF);
    check("rdata_at_lat", rdata, 64'h0004_0003_0002_0001);
    settle();
    check("lane_valid_before_capture", 64'(lane_valid), 64'h0);
    step(1'b0, 4'hF);
    settle();
    check("first_lane_valid", 64'(lane_valid), 64'hF);
    check("first_lane_data", lane_data, 64'h0004_0003_0002_0001);
    repeat (4) step(1'b0, 4'hF);
    // fill with no drain
    a0 = acc_total;
    repeat (20) step(1'b1, 4'h0);
    settle();
    check("fill_accepts", 64'(acc_total - a0), 64'd8);
    check("fill_rvalid", 64'(r_o_vaild), 64'd0);
    check("fill_lane_valid", 64'(lane_valid), 64'hF);
    for (int k = 0; k < 4; k++) check($sformatf("fill_count%0d", k), 64'(exp_q[k].size()), 64'd8);
`ifdef RAM_READ_SPLITTER_LEVEL_EN
    check("fill_level", 64'(lane_level), 64'h8888);
`endif
    // one pop on lane 0 only
    step(1'b1, 4'b0001);
    repeat (3) begin
      step(1'b1, 4'h0);
      settle();
      check("partial_pop_rvalid", 64'(r_o_vaild), 64'd0);
    end
    check("partial_pop_count0", 64'(exp_q[0].size()), 64'd7);
    check("partial_pop_lane_valid", 64'(lane_valid), 64'hF);
`ifdef RAM_READ_SPLITTER_LEVEL_EN
    check("partial_pop_level", 64'(lane_level), 64'h8887);
`endif
    repeat (12) step(1'b0, 4'hF);
    settle();
    check("drain1_lane_valid", 64'(lane_valid), 64'h0);
    // full throughput while draining every cycle
    a0 = acc_total;
    repeat (20) step(1'b1, 4'hF);
    settle();
    check("throughput_accepts", 64'(acc_total - a0), 64'd20);
    // random stress, then toggling ready with full drain until 1000 words
    repeat (300) step(1'($urandom_range(0, 1)), 4'($urandom));
    p0 = pops[0];
    n = 0;
    while (pops[0] - p0 < 1000 && n < 4000) begin
      step(1'(n % 2 == 0), 4'hF);
      n++;
    end
    check("toggle_1000_words", 64'(pops[0] - p0 >= 1000), 64'd1);
    repeat (12) step(1'b0, 4'hF);
    settle();
    check("drain2_lane_valid", 64'(lane_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain2_leftover%0d", k), 64'(exp_q[k].size()), 64'd0);
      check($sformatf("pops_equal%0d", k), 64'(pops[k]), 64'(pops[0]));
    end
`ifdef RAM_READ_SPLITTER_LEVEL_EN
    repeat (3) step(1'b1, 4'h0);
    repeat (4) step(1'b0, 4'h0);
    step(1'b0, 4'b0100);
    step(1'b0, 4'h0);
    settle();
    check("level_lane2", 64'(lane_level[2*CW+:CW]), 64'd2);
    check("level_all", 64'(lane_level), 64'h3233);
    repeat (6) step(1'b0, 4'hF);
`endif
    // reset with two reads in flight and five words stored
    a0 = acc_total;
    n = 0;
    while (acc_total - a0 < 7 && n < 50) begin
      step(1'b1, 4'h0);
      n++;
    end
    check("pre_reset_accepts", 64'(acc_total - a0), 64'd7);
    step(1'b0, 4'h0);
    check("pre_reset_lane_valid", 64'(lane_valid), 64'hF);
`ifdef RAM_READ_SPLITTER_LEVEL_EN
    check("pre_reset_level", 64'(lane_level), 64'h5555);
`endif
    reset = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    check("midreset_rvalid", 64'(r_o_vaild), 64'd1);
    check("midreset_lane_data", lane_data, 64'h0);
    #1;
    reset = 1'b1;
    repeat (5) begin
      settle();
      check("post_reset_lane_valid", 64'(lane_valid), 64'h0);
      step(1'b0, 4'h0);
    end
    check("post_reset_rvalid", 64'(r_o_vaild), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
